// File: rtl/caliptra_fpga_sync_axil_init_pkg.sv
// Shared types for the fpga_sync AXI4-Lite initiator: FSM states, AXI response codes,
// and default-width command/response records.
package caliptra_fpga_sync_axil_init_pkg;

    localparam int AXIL_ADDR_W = 32;
    localparam int AXIL_DATA_W = 64;
    localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_REQ   = 3'd1,
        WR_RESP  = 3'd2,
        RD_REQ   = 3'd3,
        RD_DATA  = 3'd4,
        RSP      = 3'd5
    } axil_state_t;

    typedef struct packed {
        logic                   write;
        logic [AXIL_ADDR_W-1:0] addr;
        logic [AXIL_DATA_W-1:0] wdata;
        logic [AXIL_STRB_W-1:0] wstrb;
    } axil_cmd_t;

    typedef struct packed {
        logic [AXIL_DATA_W-1:0] rdata;
        logic [1:0]             resp;
        logic                   timeout;
    } axil_rsp_t;

endpackage

// File: rtl/caliptra_fpga_sync_axil_timeout.sv
// Per-transaction wait-cycle counter; expired pulses on the LIMIT-th enabled cycle after clear.
module caliptra_fpga_sync_axil_timeout #(
    parameter  int LIMIT = 1024,
    localparam int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic aclk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge aclk) begin
        if (!rstn || clear) begin
            count <= '0;
        end else if (enable && (count != CNT_W'(LIMIT))) begin
            count <= count + CNT_W'(1);
        end
    end

    // Fires in the cycle whose increment would reach LIMIT, so the abort lands exactly LIMIT cycles in.
    assign expired = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/caliptra_fpga_sync_axil_initiator.sv
// AXI4-Lite initiator for the fpga_sync fabric: one local command at a time, one response back.
// Optional abort-on-timeout enabled by defining CALIPTRA_FPGA_SYNC_AXIL_TIMEOUT_EN.
module caliptra_fpga_sync_axil_initiator
    import caliptra_fpga_sync_axil_init_pkg::*;
#(
    parameter  int         ADDR_W         = 32,
    parameter  int         DATA_W         = 64,
    parameter  logic [2:0] PROT           = 3'b000,
    parameter  int         TIMEOUT_CYCLES = 1024,
    localparam int         STRB_W         = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awprot,
    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    output axil_state_t       dbg_state
);

    // Every channel (cmd, rsp, AW, W, B, AR, R) transfers on a rising edge where valid && ready;
    // a source holds valid and payload steady until that edge, and ready never gates valid.

    axil_state_t state;
    logic        timeout_hit;
    logic        aw_ok;
    logic        w_ok;
    logic        step_done;

    assign cmd_ready = (state == IDLE);
    assign dbg_state = state;
    assign awprot    = PROT;
    assign arprot    = PROT;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef CALIPTRA_FPGA_SYNC_AXIL_TIMEOUT_EN
    logic cmd_fire;
    logic wait_state;

    assign cmd_fire   = cmd_valid && cmd_ready;
    assign wait_state = (state == WR_REQ) || (state == WR_RESP) ||
                        (state == RD_REQ) || (state == RD_DATA);

    caliptra_fpga_sync_axil_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .aclk    (aclk),
        .rstn    (rstn),
        .clear   (cmd_fire),
        .enable  (wait_state),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // A channel is finished once its valid is already low or is handshaking this edge.
    assign aw_ok = !awvalid || awready;
    assign w_ok  = !wvalid  || wready;

    always_comb begin
        step_done = 1'b0;
        case (state)
            WR_REQ:  step_done = aw_ok && w_ok;
            WR_RESP: step_done = bvalid;
            RD_REQ:  step_done = arready;
            RD_DATA: step_done = rvalid;
            default: step_done = 1'b0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!rstn) begin
            state       <= IDLE;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            arvalid     <= 1'b0;
            bready      <= 1'b0;
            rready      <= 1'b0;
            awaddr      <= '0;
            wdata       <= '0;
            wstrb       <= '0;
            araddr      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= AXI_RESP_OKAY;
            rsp_timeout <= 1'b0;
        end else if (timeout_hit && !step_done) begin
            // A handshake landing in the expiry cycle takes the normal path instead.
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            arvalid     <= 1'b0;
            bready      <= 1'b0;
            rready      <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_resp    <= AXI_RESP_SLVERR;
            rsp_timeout <= 1'b1;
            state       <= RSP;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_write) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            awaddr  <= cmd_addr;
                            wdata   <= cmd_wdata;
                            wstrb   <= cmd_wstrb;
                            state   <= WR_REQ;
                        end else begin
                            arvalid <= 1'b1;
                            araddr  <= cmd_addr;
                            state   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if (step_done) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready      <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_resp    <= bresp;
                        rsp_timeout <= 1'b0;
                        state       <= RSP;
                    end
                end
                RD_REQ: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rready      <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= rdata;
                        rsp_resp    <= rresp;
                        rsp_timeout <= 1'b0;
                        state       <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_caliptra_fpga_sync_axil_initiator.sv
// Bench for the fpga_sync AXI4-Lite initiator: directed table, hand-written corner sequences,
// and randomized commands checked against a memory-backed slave model.
module tb_caliptra_fpga_sync_axil_initiator;
  import caliptra_fpga_sync_axil_init_pkg::*;

  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic rstn = 1'b0;
  always #5 aclk = ~aclk;

  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = '0;
  logic [63:0] cmd_wdata = '0;
  logic [7:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 0, rsp_timeout;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready = 0, wvalid, wready = 0;
  logic [31:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        bvalid = 0, bready, arvalid, arready = 0, rvalid = 0, rready;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [63:0] rdata = '0;
  axil_state_t dbg_state;

  caliptra_fpga_sync_axil_initiator #(
    .ADDR_W(32), .DATA_W(64), .PROT(3'b000), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .dbg_state(dbg_state)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference memory model ----------------
  logic [63:0] model_mem[logic [31:0]];
  logic [63:0] slv_mem[logic [31:0]];

  function automatic logic [63:0] default_word(input logic [31:0] a);
    return {~a, a};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] model_read(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : default_word(a);
  endfunction

  function automatic logic [63:0] slv_read(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : default_word(a);
  endfunction

  // ---------------- vectors ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    int          aw_d, w_d, b_d, ar_d, r_d, rsp_d;
    bit          hold;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [63:0] d,
                              input logic [7:0] s, input int awd, input int wd, input int bd,
                              input int ard, input int rd, input int rspd, input bit hold,
                              input logic [63:0] er, input logic [1:0] es, input int el);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.wstrb = s;
    v.aw_d = awd; v.w_d = wd; v.b_d = bd; v.ar_d = ard; v.r_d = rd; v.rsp_d = rspd;
    v.hold = hold; v.exp_rdata = er; v.exp_resp = es; v.exp_lat = el;
    return v;
  endfunction

  // ---------------- slave driver tasks ----------------
  logic [31:0] obs_awaddr, obs_araddr;
  logic [63:0] obs_wdata;
  logic [7:0]  obs_wstrb;
  int          chan_bad;

  task automatic slave_aw(input int dly);
    int g = 0;
    while (!awvalid && g < 200) begin @(negedge aclk); g++; end
    if (!awvalid) begin check("aw_seen", 64'(awvalid), 64'd1); return; end
    obs_awaddr = awaddr;
    repeat (dly) begin
      @(negedge aclk);
      if (awvalid !== 1'b1 || awaddr !== obs_awaddr) chan_bad++;
    end
    awready = 1'b1;
    @(negedge aclk);
    awready = 1'b0;
    if (awvalid !== 1'b0) chan_bad++;
  endtask

  task automatic slave_w(input int dly);
    int g = 0;
    while (!wvalid && g < 200) begin @(negedge aclk); g++; end
    if (!wvalid) begin check("w_seen", 64'(wvalid), 64'd1); return; end
    obs_wdata = wdata;
    obs_wstrb = wstrb;
    repeat (dly) begin
      @(negedge aclk);
      if (wvalid !== 1'b1 || wdata !== obs_wdata || wstrb !== obs_wstrb) chan_bad++;
    end
    wready = 1'b1;
    @(negedge aclk);
    wready = 1'b0;
    if (wvalid !== 1'b0) chan_bad++;
  endtask

  task automatic slave_ar(input int dly);
    int g = 0;
    while (!arvalid && g < 200) begin @(negedge aclk); g++; end
    if (!arvalid) begin check("ar_seen", 64'(arvalid), 64'd1); return; end
    obs_araddr = araddr;
    repeat (dly) begin
      @(negedge aclk);
      if (arvalid !== 1'b1 || araddr !== obs_araddr) chan_bad++;
    end
    arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    if (arvalid !== 1'b0) chan_bad++;
  endtask

  task automatic slave_b(input int dly, input logic [1:0] resp);
    bit hs = 0;
    int g = 0;
    repeat (dly) @(negedge aclk);
    bvalid = 1'b1;
    bresp  = resp;
    while (g < 200) begin
      hs = bready;
      @(negedge aclk);
      g++;
      if (hs) break;
    end
    bvalid = 1'b0;
    if (!hs) check("b_handshake", 64'(hs), 64'd1);
  endtask

  task automatic slave_r(input int dly, input logic [63:0] d, input logic [1:0] resp);
    bit hs = 0;
    int g = 0;
    repeat (dly) @(negedge aclk);
    rvalid = 1'b1;
    rdata  = d;
    rresp  = resp;
    while (g < 200) begin
      hs = rready;
      @(negedge aclk);
      g++;
      if (hs) break;
    end
    rvalid = 1'b0;
    if (!hs) check("r_handshake", 64'(hs), 64'd1);
  endtask

  // Slave answers resp = address bits [3:2]; memory is byte-strobed.
  task automatic slave_serve(input vec_t v);
    if (v.wr) begin
      fork
        slave_aw(v.aw_d);
        slave_w(v.w_d);
      join
      slv_mem[obs_awaddr] = merge(slv_read(obs_awaddr), obs_wdata, obs_wstrb);
      slave_b(v.b_d, obs_awaddr[3:2]);
    end else begin
      slave_ar(v.ar_d);
      slave_r(v.r_d, slv_read(obs_araddr), obs_araddr[3:2]);
    end
  endtask

  // ---------------- command driver ----------------
  task automatic master_run(input vec_t v, output logic [63:0] rd, output logic [1:0] rs,
                            output logic to, output int lat);
    int g = 0;
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_wstrb = v.wstrb;
    while (!cmd_ready && g < 200) begin @(negedge aclk); g++; end
    check("accept_wait", 64'(g), 64'd0);
    @(posedge aclk);
    @(negedge aclk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge aclk); lat++; end
    rd = rsp_rdata;
    rs = rsp_resp;
    to = rsp_timeout;
    if (v.hold) begin
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h10;
    end
    repeat (v.rsp_d) begin
      @(negedge aclk);
      check("rsp_stable", 64'(rsp_valid && rsp_rdata === rd && rsp_resp === rs &&
                               rsp_timeout === to), 64'd1);
      check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    rsp_ready = 1'b0;
    check("rsp_drop", 64'(rsp_valid), 64'd0);
    if (v.hold) check("cmd_ready_after_rsp", 64'(cmd_ready), 64'd1);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [63:0] rd, e;
    logic [1:0]  rs;
    logic        to;
    int          lat;
    chan_bad = 0;
    exp_q.push_back(v.exp_rdata);
    fork
      master_run(v, rd, rs, to, lat);
      slave_serve(v);
    join
    e = exp_q.pop_front();
    check({tag, "_rdata"}, rd, e);
    check({tag, "_resp"}, 64'(rs), 64'(v.exp_resp));
    check({tag, "_timeout"}, 64'(to), 64'd0);
    check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, "_chan_protocol"}, 64'(chan_bad), 64'd0);
    if (v.wr) begin
      check({tag, "_awaddr"}, 64'(obs_awaddr), 64'(v.addr));
      check({tag, "_wdata"}, obs_wdata, v.wdata);
      check({tag, "_wstrb"}, 64'(obs_wstrb), 64'(v.wstrb));
      model_mem[v.addr] = merge(model_read(v.addr), v.wdata, v.wstrb);
    end else begin
      check({tag, "_araddr"}, 64'(obs_araddr), 64'(v.addr));
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t dir_tab[9];

  initial begin
    vec_t v;
    int   n;

    // Directed table: write 0-wait, write W-late, read with SLVERR, etc.
    dir_tab[0] = mk(1, 32'h10, 64'hDEADBEEF_01234567, 8'hFF, 0, 0, 0, 0, 0, 0, 0,
                    64'h0, 2'd0, 3);
    dir_tab[1] = mk(1, 32'h20, 64'h11112222_33334444, 8'h0F, 0, 3, 0, 0, 0, 0, 0,
                    64'h0, 2'd0, 6);
    dir_tab[2] = mk(0, 32'h08, 64'h0, 8'h00, 0, 0, 0, 0, 0, 0, 0,
                    64'h00000000_CAFEF00D, 2'd2, 3);
    dir_tab[3] = mk(0, 32'h10, 64'h0, 8'h00, 0, 0, 0, 2, 1, 0, 0,
                    64'hDEADBEEF_01234567, 2'd0, 6);
    dir_tab[4] = mk(0, 32'h20, 64'h0, 8'h00, 0, 0, 0, 0, 0, 1, 0,
                    64'hFFFFFFDF_33334444, 2'd0, 3);
    dir_tab[5] = mk(1, 32'h2C, 64'hAAAAAAAA_BBBBBBBB, 8'hF0, 2, 0, 2, 0, 0, 0, 0,
                    64'h0, 2'd3, 7);
    dir_tab[6] = mk(0, 32'h04, 64'h0, 8'h00, 0, 0, 0, 0, 0, 0, 0,
                    64'hFFFFFFFB_00000004, 2'd1, 3);
    dir_tab[7] = mk(1, 32'h34, 64'h55555555_55555555, 8'hFF, 0, 0, 0, 0, 0, 5, 1,
                    64'h0, 2'd1, 3);
    dir_tab[8] = mk(0, 32'h10, 64'h0, 8'h00, 0, 0, 0, 0, 0, 0, 0,
                    64'hDEADBEEF_01234567, 2'd0, 3);

    slv_mem[32'h08]   = 64'h00000000_CAFEF00D;
    model_mem[32'h08] = 64'h00000000_CAFEF00D;

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_bready", 64'(bready), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_resp", 64'(rsp_resp), 64'd0);
    check("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_awprot", 64'(awprot), 64'd0);
    check("rst_arprot", 64'(arprot), 64'd0);
    rstn = 1'b1;
    @(negedge aclk);

    for (int i = 0; i < 9; i++) run_vec($sformatf("dir%0d", i), dir_tab[i]);

    // Reset while waiting for B: transaction abandoned, late bvalid ignored
    awready = 1'b1; wready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30;
    cmd_wdata = 64'h0123_4567_89AB_CDEF; cmd_wstrb = 8'hFF;
    @(posedge aclk);
    @(negedge aclk);
    cmd_valid = 1'b0;
    @(negedge aclk);
    awready = 1'b0; wready = 1'b0;
    check("t6_bready_before_reset", 64'(bready), 64'd1);
    rstn = 1'b0;
    @(negedge aclk);
    check("t6_awvalid", 64'(awvalid), 64'd0);
    check("t6_wvalid", 64'(wvalid), 64'd0);
    check("t6_bready", 64'(bready), 64'd0);
    check("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    check("t6_state", 64'(dbg_state), 64'(IDLE));
    rstn = 1'b1;
    bvalid = 1'b1; bresp = 2'd0;
    repeat (3) begin
      @(negedge aclk);
      check("t6_no_rsp", 64'(rsp_valid), 64'd0);
      check("t6_no_bready", 64'(bready), 64'd0);
    end
    bvalid = 1'b0;
    @(negedge aclk);

`ifdef CALIPTRA_FPGA_SYNC_AXIL_TIMEOUT_EN
    // Read never answered on AR: abort after TO cycles with SLVERR + timeout flag
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h18;
    @(posedge aclk);
    @(negedge aclk);
    cmd_valid = 1'b0;
    n = 0;
    while (arvalid && n < 100) begin n++; @(negedge aclk); end
    check("t5_ar_cycles", 64'(n), 64'(TO));
    check("t5_rsp_valid", 64'(rsp_valid), 64'd1);
    check("t5_rsp_resp", 64'(rsp_resp), 64'd2);
    check("t5_rsp_timeout", 64'(rsp_timeout), 64'd1);
    check("t5_rsp_rdata", rsp_rdata, 64'd0);
    rsp_ready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    rsp_ready = 1'b0;
    check("t5_back_idle", 64'(cmd_ready), 64'd1);
`endif

    // Randomized commands against the memory model
    for (int i = 0; i < 40; i++) begin
      v.wr    = 1'($urandom_range(0, 1));
      v.addr  = 32'($urandom_range(0, 15)) << 2;
      v.wdata = {$urandom, $urandom};
      v.wstrb = 8'($urandom_range(0, 255));
      v.aw_d  = $urandom_range(0, 3);
      v.w_d   = $urandom_range(0, 3);
      v.b_d   = $urandom_range(0, 3);
      v.ar_d  = $urandom_range(0, 3);
      v.r_d   = $urandom_range(0, 3);
      v.rsp_d = $urandom_range(0, 2);
      v.hold  = 1'b0;
      v.exp_resp  = v.addr[3:2];
      v.exp_rdata = v.wr ? 64'd0 : model_read(v.addr);
      v.exp_lat   = v.wr ? 3 + ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + v.b_d
                         : 3 + v.ar_d + v.r_d;
      run_vec($sformatf("rnd%0d", i), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
